// File: rtl/arb_pkg.sv
// arb_pkg: shared state type and default sizing for the round-robin arbiter
package arb_pkg;
    typedef enum logic {IDLE, GRANT} arb_state_t;
    localparam int NUM_REQ  = 16;
    localparam int IDX_W    = 4;
    localparam int MAX_HOLD = 8;
endpackage

// File: rtl/binto_onehot.sv
// binto_onehot: binary index to one-hot decoder
module binto_onehot #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 16
) (
    input  logic [IN_W-1:0]  bin_i,
    output logic [OUT_W-1:0] onehot_o
);
    assign onehot_o = OUT_W'(1) << bin_i;
endmodule

// File: rtl/onehot_rr_arbiter.sv
// onehot_rr_arbiter: round-robin arbiter with locked grants, done release and hold timeout
module onehot_rr_arbiter
    import arb_pkg::*;
#(
    parameter int NUM_REQ  = arb_pkg::NUM_REQ,
    parameter int IDX_W    = arb_pkg::IDX_W,
    parameter int MAX_HOLD = arb_pkg::MAX_HOLD
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               done_i,
    output logic               gnt_valid_o,
    output logic [IDX_W-1:0]   gnt_idx_o,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic               timeout_o
);
    localparam int HOLD_W = $clog2(MAX_HOLD);

    arb_state_t          state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                to_q, to_d;
    logic [NUM_REQ-1:0]  onehot;
    logic [IDX_W-1:0]    win;
    logic                any_req, hold_max, release_ev;

    // first set request bit at or above ptr, wrapping modulo NUM_REQ
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                 input logic [IDX_W-1:0] ptr);
        logic [IDX_W-1:0] j;
        logic             found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = ptr + IDX_W'(i);
            if (!found && req[j]) begin
                rr_pick = j;
                found   = 1'b1;
            end
        end
        return rr_pick;
    endfunction

    assign any_req    = |req_i;
    assign win        = rr_pick(req_i, ptr_q);
    assign hold_max   = hold_q == HOLD_W'(MAX_HOLD - 1);
    assign release_ev = done_i || hold_max;

    // next-state: grant from IDLE, hold/release/regrant in GRANT
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        to_d    = 1'b0;
        if (state_q == IDLE) begin
            if (any_req) begin
                state_d = GRANT;
                idx_d   = win;
                ptr_d   = win + IDX_W'(1);
                hold_d  = '0;
            end
        end else begin
            hold_d = hold_q + HOLD_W'(1);
            if (release_ev) begin
                to_d   = !done_i;
                hold_d = '0;
                if (any_req) begin
                    idx_d = win;
                    ptr_d = win + IDX_W'(1);
                end else begin
                    state_d = IDLE;
                end
            end
        end
    end

    // state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            hold_q  <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            to_q    <= to_d;
        end
    end

    binto_onehot #(.IN_W(IDX_W), .OUT_W(NUM_REQ)) u_dec (
        .bin_i    (idx_q),
        .onehot_o (onehot)
    );

    assign gnt_valid_o = state_q == GRANT;
    assign gnt_idx_o   = idx_q;
    assign gnt_o       = onehot & {NUM_REQ{gnt_valid_o}};
    assign timeout_o   = to_q;
endmodule

// File: doc/onehot_rr_arbiter.md
# onehot_rr_arbiter

Round-robin arbiter that shares one resource among NUM_REQ requesters and presents the winner as a one-hot grant vector. It sits in front of a shared datapath resource. Each grant is held until the owner signals completion, or until a hold-timeout forcibly releases it. The binary winner index is registered, and the one-hot grant is decoded from it by an instance of the team's `binto_onehot` converter.

## Interface
- NUM_REQ, 16, number of requesters; must be a power of two, ≥2
- IDX_W, 4, binary index width; equals $clog2(NUM_REQ)
- MAX_HOLD, 8, maximum consecutive cycles one grant may be held; ≥2
- clk  in  1  single clock; all state updates on the rising edge
- reset_n  in  1  reset, synchronous, active-low
- req_i  in  NUM_REQ  per-requester request level
- done_i  in  1  current owner releases the resource; sampled only in GRANT
- gnt_valid_o  out  1  a grant is active
- gnt_idx_o  out  IDX_W  binary index of the current owner
- gnt_o  out  NUM_REQ  one-hot grant, equal to `binto_onehot`(gnt_idx_o) gated by gnt_valid_o; all-zero when not valid
- timeout_o  out  1  one-cycle pulse marking a forced release

## Operation
- FSM has two states: IDLE and GRANT. Reset state is IDLE.
- Priority pointer ptr has width IDX_W and resets to 0.
- Arbitration:
  - Scan req_i starting at ptr, upward with modulo-NUM_REQ wrap.
  - The first set bit wins.
  - On a grant to index k, ptr becomes k+1. The increment wraps naturally in IDX_W bits, so 15→0.
- IDLE:
  - If any req_i bit is set: grant the winner, go to GRANT, and clear hold_cnt.
  - If no request: stay in IDLE.
  - done_i is ignored.
- GRANT:
  - The grant is locked. The owner dropping its req_i bit does not release it; only done_i or timeout does.
  - hold_cnt increments each cycle in GRANT.
  - Release event: done_i=1, or hold_cnt==MAX_HOLD-1.
  - On release: re-arbitrate in the same cycle using the updated ptr (owner+1), so the old owner has lowest priority.
    - Any request present: grant the new winner, stay in GRANT, clear hold_cnt. There is no bubble.
    - No request present: go to IDLE and clear gnt_valid_o.
  - Forced release (timeout without done_i): set timeout_o for the next cycle only.
  - done_i and timeout in the same cycle: treat as a normal release; timeout_o stays 0.
- hold_cnt is $clog2(MAX_HOLD) bits wide and saturates logically via the release, so it never exceeds MAX_HOLD-1.
- gnt_idx_o holds its last value when not valid. It is 0 only after reset.

## Timing
- Reset values, applied at the first rising edge with reset_n=0: state=IDLE, ptr=0, hold_cnt=0, gnt_valid_o=0, gnt_idx_o=0, gnt_o=0, timeout_o=0.
- Reset mid-grant: all outputs are zero in the cycle after the edge, and rotation restarts from 0.
- Grant latency: a req_i seen at edge e produces gnt_valid_o/gnt_o valid after edge e, i.e. one cycle.
- Release:
  - done_i sampled at edge e ends the old grant after e.
  - The successor grant, if any, is visible in that same following cycle.
- Timeout: a grant first visible in cycle c is forcibly released at the end of cycle c+MAX_HOLD-1. timeout_o is high in cycle c+MAX_HOLD.
- gnt_o is combinational from registered gnt_idx_o/gnt_valid_o, so it has no extra latency.

## Structure
- Shared package arb_pkg holds:
  - typedef enum logic {IDLE, GRANT} arb_state_t
  - the default localparams NUM_REQ/IDX_W/MAX_HOLD
- Sub-module: instance of `binto_onehot` #(IDX_W, NUM_REQ) driving the ungated one-hot, which is then ANDed with gnt_valid_o.
- The rotating-priority search is a local function in the arbiter. It is not a separate module.

## Test plan
All scenarios use NUM_REQ=16, MAX_HOLD=8.
- Reset: hold reset_n=0 for 2 cycles with req_i=16'hFFFF → all outputs 0. The first edge after release gives gnt_idx_o=0, gnt_o=16'h0001, gnt_valid_o=1.
- Rotation: req_i=16'h8421 held, done_i pulsed one cycle in each grant → gnt_idx_o sequence 0,5,10,15,0. There are no idle cycles between grants.
- Wrap: grant index 14 first, then req_i=16'h4001 with done_i → next owner is 0, not 14 (the search wraps 15→0).
- Timeout: req_i=16'h0008, done_i=0 → gnt_o=16'h0008 for 8 cycles. timeout_o pulses once, and index 3 is regranted immediately with hold_cnt cleared.
- Done+timeout collision: done_i=1 on the 8th held cycle → release with timeout_o=0. With req_i=0, gnt_valid_o=0 on the next cycle.
- Lock and ignore:
  - The owner drops req_i mid-grant → grant remains until done_i.
  - done_i=1 in IDLE → no state change.
  - reset_n=0 during GRANT → outputs 0 next cycle, ptr back to 0.
